// File: rtl/mem_bus_arbiter.sv
// Two-client (icache/dcache) arbiter for the shared proc2mem/mem2proc bus.
// Tracks load-tag ownership to route returns, and guarantees the icache is served periodically.
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      ic_command,
    input  logic [XLEN-1:0] ic_addr,
    input  logic [1:0]      dc_command,
    input  logic [XLEN-1:0] dc_addr,
    input  logic [63:0]     dc_data,
    input  logic [1:0]      dc_size,
    output logic [3:0]      ic_response,
    output logic [3:0]      dc_response,
    output logic [3:0]      ic_data_tag,
    output logic [3:0]      dc_data_tag,
    output logic [63:0]     bus_data_out,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_size,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic            tag_error
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] SIZE_DOUBLE = 2'd3;

    logic [NUM_TAGS-1:0] tag_valid_r;
    logic [NUM_TAGS-1:0] tag_owner_r;
    logic [2:0]          starve_cnt_r;
    logic                tag_error_r;

    logic ic_req_s, dc_req_s, force_ic_s;
    logic grant_ic_s, grant_dc_s;
    logic ret_hit_s, alloc_s, alloc_owner_s, error_s;

    // Arbitration, bus forwarding and return routing.
    always_comb begin
        ic_req_s         = (ic_command == BUS_LOAD);
        dc_req_s         = (dc_command == BUS_LOAD) || (dc_command == BUS_STORE);
        force_ic_s       = (starve_cnt_r >= 3'(STARVE_LIMIT));
        grant_ic_s       = !reset && ic_req_s && (!dc_req_s || force_ic_s);
        grant_dc_s       = !reset && dc_req_s && !grant_ic_s;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = 64'd0;
        proc2mem_size    = 2'd0;
        ic_response      = 4'd0;
        dc_response      = 4'd0;
        ic_data_tag      = 4'd0;
        dc_data_tag      = 4'd0;
        if (grant_ic_s) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = ic_addr;
            proc2mem_size    = SIZE_DOUBLE;
            ic_response      = mem2proc_response;
        end else if (grant_dc_s) begin
            proc2mem_command = dc_command;
            proc2mem_addr    = dc_addr;
            proc2mem_data    = dc_data;
            proc2mem_size    = dc_size;
            dc_response      = mem2proc_response;
        end else begin
            proc2mem_command = BUS_NONE;
        end
        ret_hit_s = !reset && (mem2proc_tag != 4'd0) && tag_valid_r[mem2proc_tag];
        if (ret_hit_s) begin
            if (tag_owner_r[mem2proc_tag]) begin
                dc_data_tag = mem2proc_tag;
            end else begin
                ic_data_tag = mem2proc_tag;
            end
        end else begin
            ic_data_tag = 4'd0;
        end
        alloc_s       = (mem2proc_response != 4'd0) &&
                        (grant_ic_s || (grant_dc_s && (dc_command == BUS_LOAD)));
        alloc_owner_s = grant_dc_s;
        // A reallocation is legal only when the same tag is being retired this cycle.
        error_s = !reset && (
                      ((mem2proc_tag != 4'd0) && !tag_valid_r[mem2proc_tag]) ||
                      (ic_command == BUS_STORE) ||
                      (alloc_s && tag_valid_r[mem2proc_response] &&
                       !(ret_hit_s && (mem2proc_tag == mem2proc_response))));
    end

    // Owner table, starvation counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid_r  <= '0;
            tag_owner_r  <= '0;
            starve_cnt_r <= 3'd0;
            tag_error_r  <= 1'b0;
        end else begin
            if (!ic_req_s) begin
                starve_cnt_r <= 3'd0;
            end else if (!grant_ic_s) begin
                if (starve_cnt_r != 3'd7) begin
                    starve_cnt_r <= starve_cnt_r + 3'd1;
                end
            end else if (force_ic_s && (mem2proc_response == 4'd0)) begin
                starve_cnt_r <= starve_cnt_r;
            end else begin
                starve_cnt_r <= 3'd0;
            end
            if (ret_hit_s) begin
                tag_valid_r[mem2proc_tag] <= 1'b0;
            end
            if (alloc_s) begin
                tag_valid_r[mem2proc_response] <= 1'b1;
                tag_owner_r[mem2proc_response] <= alloc_owner_s;
            end
            if (error_s) begin
                tag_error_r <= 1'b1;
            end
        end
    end

    assign tag_error    = tag_error_r;
    assign bus_data_out = mem2proc_data;

endmodule
